// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline types, funct3 size codes and store lane helpers
package mem_stage_pkg;

   localparam int XLEN = 64;

   localparam logic [2:0] SZ_B  = 3'd0;
   localparam logic [2:0] SZ_H  = 3'd1;
   localparam logic [2:0] SZ_W  = 3'd2;
   localparam logic [2:0] SZ_D  = 3'd3;
   localparam logic [2:0] SZ_BU = 3'd4;
   localparam logic [2:0] SZ_HU = 3'd5;
   localparam logic [2:0] SZ_WU = 3'd6;

   typedef enum logic {
      MS_IDLE = 1'b0,
      MS_BUSY = 1'b1
   } ms_state_t;

   // funct3 = 7 has no encoding of its own and falls through to doubleword everywhere
   function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] lane);
      case (funct3)
         SZ_B, SZ_BU: return 1'b0;
         SZ_H, SZ_HU: return lane[0];
         SZ_W, SZ_WU: return |lane[1:0];
         default:     return |lane;
      endcase
   endfunction

   function automatic logic [7:0] store_strobe(input logic [2:0] funct3, input logic [2:0] lane);
      logic [7:0] mask;
      case (funct3)
         SZ_B, SZ_BU: mask = 8'h01;
         SZ_H, SZ_HU: mask = 8'h03;
         SZ_W, SZ_WU: mask = 8'h0F;
         default:     mask = 8'hFF;
      endcase
      return mask << lane;
   endfunction

   function automatic logic [XLEN-1:0] store_replicate(input logic [2:0] funct3,
                                                       input logic [XLEN-1:0] value);
      case (funct3)
         SZ_B, SZ_BU: return {8{value[7:0]}};
         SZ_H, SZ_HU: return {4{value[15:0]}};
         SZ_W, SZ_WU: return {2{value[31:0]}};
         default:     return value;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory valid/ready bus between the MEM stage and data memory
interface mem_stage_if #(parameter int XLEN = 64);

   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [7:0]      wstrb;
   logic            ready;
   logic [XLEN-1:0] rdata;

   modport master (output req, we, addr, wdata, wstrb, input ready, rdata);
   modport slave  (input req, we, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - lane select and sign/zero extension of load data
module load_align import mem_stage_pkg::*; (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      lane,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] shifted;
   logic            zext;

   always_comb begin
      shifted = rdata >> {lane, 3'b000};
      zext    = funct3 inside {SZ_BU, SZ_HU, SZ_WU};
      case (funct3)
         SZ_B, SZ_BU: data = {{56{~zext & shifted[7]}},  shifted[7:0]};
         SZ_H, SZ_HU: data = {{48{~zext & shifted[15]}}, shifted[15:0]};
         SZ_W, SZ_WU: data = {{32{~zext & shifted[31]}}, shifted[31:0]};
         default:     data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: runs loads/stores over the dmem bus and registers WB results
module mem_stage import mem_stage_pkg::*; #(
   parameter int XLEN = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic             ex_load,
   input  logic             ex_store,
   input  logic [2:0]       ex_funct3,
   input  logic [4:0]       ex_rd,
   input  logic [XLEN-1:0]  ex_alu_res,
   input  logic [XLEN-1:0]  ex_store_value,
   input  logic             flush,
   mem_stage_if.master      dmem,
   output logic             stall_o,
   output logic             mem_valid,
   output logic [4:0]       mem_rd,
   output logic [XLEN-1:0]  mem_res,
   output logic             exc_misalign
);

   ms_state_t       state, state_next;
   logic [2:0]      ex_lane;
   logic            is_store, is_mem, misal, take, accept, bus_req;

   logic            req_we;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [7:0]      req_wstrb;
   logic [2:0]      req_funct3;
   logic [2:0]      req_lane;
   logic [4:0]      req_rd;
   logic            kill;
   logic [XLEN-1:0] load_data;

   // a load+store combination is a load, so only a pure store writes
   assign ex_lane  = ex_alu_res[2:0];
   assign is_store = ex_store & ~ex_load;
   assign is_mem   = ex_load | ex_store;
   assign misal    = misaligned(ex_funct3, ex_lane);
   assign take     = ex_valid & ~flush;
   assign accept   = (state == MS_IDLE) & take & is_mem & ~misal;

   assign dmem.req   = bus_req;
   assign dmem.we    = req_we;
   assign dmem.addr  = req_addr;
   assign dmem.wdata = req_wdata;
   assign dmem.wstrb = req_wstrb;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= MS_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         MS_IDLE: if (accept)     state_next = MS_BUSY;
         MS_BUSY: if (dmem.ready) state_next = MS_IDLE;
         default:                 state_next = MS_IDLE;
      endcase
   end

   // the held EX instruction is the access itself, so upstream is frozen until ready
   always_comb begin
      bus_req = 1'b0;
      stall_o = 1'b0;
      case (state)
         MS_IDLE: stall_o = accept;
         MS_BUSY: begin
            bus_req = 1'b1;
            stall_o = ~dmem.ready;
         end
         default: ;
      endcase
      if (!rst_n) stall_o = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_we     <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
         req_wstrb  <= '0;
         req_funct3 <= '0;
         req_lane   <= '0;
         req_rd     <= '0;
      end else if (accept) begin
         req_we     <= is_store;
         req_addr   <= {ex_alu_res[XLEN-1:3], 3'b000};
         req_wdata  <= is_store ? store_replicate(ex_funct3, ex_store_value) : '0;
         req_wstrb  <= is_store ? store_strobe(ex_funct3, ex_lane) : 8'h00;
         req_funct3 <= ex_funct3;
         req_lane   <= ex_lane;
         req_rd     <= ex_rd;
      end
   end

   // the bus cannot abort, so a flush while busy only suppresses the retirement
   always_ff @(posedge clk) begin
      if (!rst_n)                 kill <= 1'b0;
      else if (state == MS_BUSY)  kill <= dmem.ready ? 1'b0 : (kill | flush);
      else                        kill <= 1'b0;
   end

   load_align u_load_align (
      .rdata  (dmem.rdata),
      .lane   (req_lane),
      .funct3 (req_funct3),
      .data   (load_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_valid    <= 1'b0;
         mem_rd       <= '0;
         mem_res      <= '0;
         exc_misalign <= 1'b0;
      end else begin
         mem_valid    <= 1'b0;
         mem_rd       <= '0;
         exc_misalign <= 1'b0;
         if (state == MS_BUSY) begin
            if (dmem.ready) begin
               mem_res <= req_we ? '0 : load_data;
               if (!(kill | flush)) begin
                  mem_valid <= 1'b1;
                  mem_rd    <= req_we ? 5'd0 : req_rd;
               end
            end
         end else if (take) begin
            if (!is_mem) begin
               mem_valid <= 1'b1;
               mem_rd    <= ex_rd;
               mem_res   <= ex_alu_res;
            end else if (misal) begin
               // faulting address is kept in mem_res for the trap handler
               mem_valid    <= 1'b1;
               exc_misalign <= 1'b1;
               mem_res      <= ex_alu_res;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with directed and randomized accesses
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_load, ex_store, flush;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd;
   logic [63:0] ex_alu_res, ex_store_value;
   logic        stall_o, mem_valid, exc_misalign;
   logic [4:0]  mem_rd;
   logic [63:0] mem_res;

   int errors = 0;
   int checks = 0;

   mem_stage_if #(.XLEN(64)) dmem ();

   mem_stage #(.XLEN(64)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_load        (ex_load),
      .ex_store       (ex_store),
      .ex_funct3      (ex_funct3),
      .ex_rd          (ex_rd),
      .ex_alu_res     (ex_alu_res),
      .ex_store_value (ex_store_value),
      .flush          (flush),
      .dmem           (dmem),
      .stall_o        (stall_o),
      .mem_valid      (mem_valid),
      .mem_rd         (mem_rd),
      .mem_res        (mem_res),
      .exc_misalign   (exc_misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; flush = 1'b0;
      ex_funct3 = 3'd0; ex_rd = 5'd0; ex_alu_res = 64'd0; ex_store_value = 64'd0;
   endtask

   task automatic present(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] sv);
      ex_valid = 1'b1; ex_load = ld; ex_store = st; flush = 1'b0;
      ex_funct3 = f3; ex_rd = rd; ex_alu_res = addr; ex_store_value = sv;
   endtask

   function automatic int size_bytes(input logic [2:0] f3);
      if (f3 == 3'd7) return 8;
      return 1 << (f3 % 4);
   endfunction

   function automatic logic [63:0] model_load(input logic [2:0] f3, input int lane,
                                              input logic [63:0] rdata);
      logic [63:0] v = 64'd0;
      int nb = size_bytes(f3);
      bit uns = (f3 == 3'd4) || (f3 == 3'd5) || (f3 == 3'd6);
      for (int b = 0; b < nb; b++) v[b*8 +: 8] = rdata[(lane + b)*8 +: 8];
      if (!uns && v[nb*8-1])
         for (int b = nb; b < 8; b++) v[b*8 +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic logic [63:0] model_wdata(input logic [2:0] f3, input logic [63:0] sv);
      logic [63:0] w;
      int nb = size_bytes(f3);
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = sv[(b % nb)*8 +: 8];
      return w;
   endfunction

   function automatic logic [7:0] model_wstrb(input logic [2:0] f3, input int lane);
      int s = ((1 << size_bytes(f3)) - 1) << lane;
      return s[7:0];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      present(1'b1, 1'b0, 3'd3, 5'd4, 64'h100, 64'd0);
      dmem.ready = 1'b0; dmem.rdata = 64'd0;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
      tick(); tick();
      checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem.req); end
      checks++; if ({dmem.we, dmem.addr, dmem.wdata, dmem.wstrb} !== 137'd0) begin errors++; $display("FAIL reset_bus: addr=%h wdata=%h wstrb=%h want 0", dmem.addr, dmem.wdata, dmem.wstrb); end
      checks++; if ({mem_valid, mem_rd, mem_res, exc_misalign} !== 71'd0) begin errors++; $display("FAIL reset_out: valid=%b rd=%0d res=%h exc=%b want 0", mem_valid, mem_rd, mem_res, exc_misalign); end
      clear_ex();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      present(1'b0, 1'b0, 3'd0, 5'd5, 64'h1234, 64'd0);
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", stall_o); end
      tick();
      clear_ex();
      checks++; if (mem_valid !== 1'b1 || mem_rd !== 5'd5 || mem_res !== 64'h1234) begin errors++; $display("FAIL alu_result: valid=%b rd=%0d res=%h want 1/5/1234", mem_valid, mem_rd, mem_res); end
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall_after: got %b want 0", stall_o); end
      tick();
      checks++; if (mem_valid !== 1'b0 || mem_rd !== 5'd0) begin errors++; $display("FAIL alu_one_cycle: valid=%b rd=%0d want 0/0", mem_valid, mem_rd); end
   endtask

   task automatic test_lb();
      present(1'b1, 1'b0, 3'd0, 5'd7, 64'h1003, 64'd0);
      dmem.ready = 1'b1; dmem.rdata = 64'h0000_0000_8000_0000;
      #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lb_accept_stall: got %b want 1", stall_o); end
      tick();
      #1;
      checks++; if (dmem.req !== 1'b1 || dmem.addr !== 64'h1000 || dmem.we !== 1'b0) begin errors++; $display("FAIL lb_bus: req=%b addr=%h we=%b want 1/1000/0", dmem.req, dmem.addr, dmem.we); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lb_busy_stall: got %b want 0", stall_o); end
      tick();
      clear_ex(); dmem.ready = 1'b0;
      checks++; if (mem_valid !== 1'b1 || mem_rd !== 5'd7 || mem_res !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_result: valid=%b rd=%0d res=%h want 1/7/ffffffffffffff80", mem_valid, mem_rd, mem_res); end
      #1;
      checks++; if (dmem.req !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL lb_idle: req=%b stall=%b want 0/0", dmem.req, stall_o); end
      tick();
   endtask

   task automatic test_sh_wait();
      int stall_cnt = 0;
      present(1'b0, 1'b1, 3'd1, 5'd9, 64'h2006, 64'h0000_0000_0000_ABCD);
      dmem.ready = 1'b0;
      #1;
      if (stall_o) stall_cnt++;
      tick();
      for (int i = 0; i <= 3; i++) begin
         dmem.ready = (i == 3);
         #1;
         if (stall_o) stall_cnt++;
         checks++; if (dmem.wstrb !== 8'hC0 || dmem.wdata[63:48] !== 16'hABCD || dmem.we !== 1'b1) begin errors++; $display("FAIL sh_bus[%0d]: wstrb=%h wdata=%h we=%b want c0/abcd/1", i, dmem.wstrb, dmem.wdata, dmem.we); end
         tick();
      end
      clear_ex(); dmem.ready = 1'b0;
      checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL sh_stall_cycles: got %0d want 4", stall_cnt); end
      checks++; if (mem_valid !== 1'b1 || mem_rd !== 5'd0 || mem_res !== 64'd0) begin errors++; $display("FAIL sh_result: valid=%b rd=%0d res=%h want 1/0/0", mem_valid, mem_rd, mem_res); end
      tick();
   endtask

   task automatic test_misalign();
      present(1'b1, 1'b0, 3'd2, 5'd3, 64'h3002, 64'd0);
      #1;
      checks++; if (dmem.req !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL mis_accept: req=%b stall=%b want 0/0", dmem.req, stall_o); end
      tick();
      clear_ex();
      #1;
      checks++; if (exc_misalign !== 1'b1 || mem_valid !== 1'b1 || mem_rd !== 5'd0 || dmem.req !== 1'b0) begin errors++; $display("FAIL mis_result: exc=%b valid=%b rd=%0d req=%b want 1/1/0/0", exc_misalign, mem_valid, mem_rd, dmem.req); end
      tick();
      checks++; if (exc_misalign !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL mis_clear: exc=%b valid=%b want 0/0", exc_misalign, mem_valid); end
   endtask

   task automatic test_flush_idle();
      present(1'b1, 1'b0, 3'd3, 5'd12, 64'h5000, 64'd0);
      flush = 1'b1;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", stall_o); end
      tick();
      clear_ex();
      #1;
      checks++; if (mem_valid !== 1'b0 || dmem.req !== 1'b0) begin errors++; $display("FAIL flush_idle_drop: valid=%b req=%b want 0/0", mem_valid, dmem.req); end
      tick();
   endtask

   task automatic test_flush_busy();
      present(1'b1, 1'b0, 3'd3, 5'd11, 64'h4008, 64'd0);
      dmem.ready = 1'b0; dmem.rdata = 64'h0123_4567_89AB_CDEF;
      tick();
      flush = 1'b1;
      #1;
      checks++; if (stall_o !== 1'b1 || dmem.req !== 1'b1) begin errors++; $display("FAIL flush_busy_w0: stall=%b req=%b want 1/1", stall_o, dmem.req); end
      tick();
      flush = 1'b0;
      #1;
      checks++; if (stall_o !== 1'b1 || dmem.req !== 1'b1 || dmem.addr !== 64'h4008) begin errors++; $display("FAIL flush_busy_w1: stall=%b req=%b addr=%h want 1/1/4008", stall_o, dmem.req, dmem.addr); end
      tick();
      dmem.ready = 1'b1;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_busy_done_stall: got %b want 0", stall_o); end
      tick();
      clear_ex(); dmem.ready = 1'b0;
      checks++; if (mem_valid !== 1'b0 || mem_rd !== 5'd0) begin errors++; $display("FAIL flush_busy_kill: valid=%b rd=%0d want 0/0", mem_valid, mem_rd); end
      #1;
      checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL flush_busy_idle: req=%b want 0", dmem.req); end
      tick();
   endtask

   task automatic test_random();
      bit ld, st, mem, mis, idle_flush;
      logic [2:0] f3;
      logic [4:0] rd;
      logic [63:0] addr, sv, rdata;
      int nb, lane, waits, flush_at, kind;
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 3);
         ld = (kind == 1) || (kind == 3);
         st = (kind == 2) || (kind == 3);
         mem = ld | st;
         f3 = 3'($urandom_range(0, 7));
         nb = size_bytes(f3);
         rd = 5'($urandom_range(0, 31));
         addr = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) addr = addr & ~64'(nb - 1);
         lane = int'(addr % 8);
         mis = mem && ((addr & 64'(nb - 1)) != 0);
         sv = {$urandom, $urandom};
         rdata = {$urandom, $urandom};
         waits = $urandom_range(0, 3);
         flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, waits) : -1;
         idle_flush = ($urandom_range(0, 7) == 0);
         present(ld, st, f3, rd, addr, sv);
         flush = idle_flush;
         dmem.ready = 1'(($urandom_range(0, 1)));
         #1;
         checks++; if (stall_o !== (mem && !mis && !idle_flush) || dmem.req !== 1'b0) begin errors++; $display("FAIL rnd%0d_accept: stall=%b req=%b", n, stall_o, dmem.req); end
         tick();
         if (idle_flush) begin
            clear_ex();
            checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle_flush: valid=%b want 0", n, mem_valid); end
         end else if (!mem || mis) begin
            clear_ex();
            checks++; if (mem_valid !== 1'b1 || mem_rd !== (mem ? 5'd0 : rd) || exc_misalign !== mis) begin errors++; $display("FAIL rnd%0d_direct: valid=%b rd=%0d exc=%b want 1/%0d/%b", n, mem_valid, mem_rd, exc_misalign, mem ? 5'd0 : rd, mis); end
            checks++; if (!mem && mem_res !== addr) begin errors++; $display("FAIL rnd%0d_alu_res: got %h want %h", n, mem_res, addr); end
         end else begin
            flush = 1'b0;
            for (int i = 0; i <= waits; i++) begin
               dmem.ready = (i == waits);
               dmem.rdata = (i == waits) ? rdata : {$urandom, $urandom};
               flush = (i == flush_at);
               #1;
               checks++; if (dmem.req !== 1'b1 || dmem.addr !== (addr & ~64'h7) || dmem.we !== (st && !ld) || stall_o !== (i != waits) || mem_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy%0d: req=%b addr=%h we=%b stall=%b valid=%b", n, i, dmem.req, dmem.addr, dmem.we, stall_o, mem_valid); end
               if (st && !ld) begin
                  checks++; if (dmem.wstrb !== model_wstrb(f3, lane) || dmem.wdata !== model_wdata(f3, sv)) begin errors++; $display("FAIL rnd%0d_store_bus: wstrb=%h wdata=%h want %h/%h", n, dmem.wstrb, dmem.wdata, model_wstrb(f3, lane), model_wdata(f3, sv)); end
               end
               tick();
            end
            clear_ex(); dmem.ready = 1'b0;
            if (flush_at >= 0) begin
               checks++; if (mem_valid !== 1'b0 || mem_rd !== 5'd0) begin errors++; $display("FAIL rnd%0d_killed: valid=%b rd=%0d want 0/0", n, mem_valid, mem_rd); end
            end else if (st && !ld) begin
               checks++; if (mem_valid !== 1'b1 || mem_rd !== 5'd0 || mem_res !== 64'd0) begin errors++; $display("FAIL rnd%0d_store_ret: valid=%b rd=%0d res=%h want 1/0/0", n, mem_valid, mem_rd, mem_res); end
            end else begin
               checks++; if (mem_valid !== 1'b1 || mem_rd !== rd || mem_res !== model_load(f3, lane, rdata)) begin errors++; $display("FAIL rnd%0d_load_ret: valid=%b rd=%0d res=%h want 1/%0d/%h", n, mem_valid, mem_rd, mem_res, rd, model_load(f3, lane, rdata)); end
            end
         end
         tick();
         checks++; if (mem_valid !== 1'b0 || mem_rd !== 5'd0 || dmem.req !== 1'b0) begin errors++; $display("FAIL rnd%0d_settle: valid=%b rd=%0d req=%b want 0/0/0", n, mem_valid, mem_rd, dmem.req); end
      end
   endtask

   task automatic test_reset_busy();
      present(1'b0, 1'b1, 3'd3, 5'd2, 64'h6000, 64'hDEAD_BEEF_CAFE_F00D);
      dmem.ready = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rstbusy_stall: got %b want 0", stall_o); end
      tick();
      checks++; if (dmem.req !== 1'b0 || dmem.we !== 1'b0 || dmem.addr !== 64'd0 || dmem.wdata !== 64'd0 || dmem.wstrb !== 8'd0) begin errors++; $display("FAIL rstbusy_bus: req=%b we=%b addr=%h wdata=%h wstrb=%h want 0", dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.wstrb); end
      checks++; if (mem_valid !== 1'b0 || mem_rd !== 5'd0 || mem_res !== 64'd0 || exc_misalign !== 1'b0) begin errors++; $display("FAIL rstbusy_out: valid=%b rd=%0d res=%h exc=%b want 0", mem_valid, mem_rd, mem_res, exc_misalign); end
      clear_ex();
      rst_n = 1'b1;
      dmem.ready = 1'b1;
      #1;
      checks++; if (dmem.req !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL rstbusy_idle: req=%b stall=%b want 0/0", dmem.req, stall_o); end
      tick();
      checks++; if (mem_valid !== 1'b0 || dmem.req !== 1'b0) begin errors++; $display("FAIL rstbusy_no_retire: valid=%b req=%b want 0/0", mem_valid, dmem.req); end
      dmem.ready = 1'b0;
   endtask

   initial begin
      clear_ex();
      test_reset();
      test_alu();
      test_lb();
      test_sh_wait();
      test_misalign();
      test_flush_idle();
      test_flush_busy();
      test_random();
      test_reset_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
